// File: rtl/char_pixel_shifter.sv
// Character-ROM fetch and MSB-first pixel serialiser; one character period of latency.
// Optional build macro INVERSE_VIDEO_EN: code MSB becomes an inverse-video flag.
module char_pixel_shifter #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int RW = 3,
  parameter int AW = CW + RW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pe,
  input  logic          ld,
  input  logic [CW-1:0] code,
  input  logic [RW-1:0] row,
  input  logic          de,
  output logic          rom_ce,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_q,
  output logic          pixel,
  output logic          de_out
);

  logic          fetch;
  logic [CW-1:0] code_a;
  logic          inv_in;

  logic [DW-1:0] hold;
  logic          hold_de;
  logic          hold_inv;
  logic [1:0]    pend_v;
  logic [1:0]    pend_de;

  logic [DW-1:0] shift;
  logic          inv_out;

  assign fetch = pe & ld;

`ifdef INVERSE_VIDEO_EN
  assign code_a = {1'b0, code[CW-2:0]};
  assign inv_in = code[CW-1];
`else
  assign code_a = code;
  assign inv_in = 1'b0;
`endif

  // ROM side: address/strobe on the fetch edge, byte captured two clocks later.
  always_ff @(posedge clock) begin
    if (reset) begin
      rom_ce   <= 1'b0;
      rom_a    <= '0;
      hold_de  <= 1'b0;
      hold_inv <= 1'b0;
      pend_v   <= '0;
      pend_de  <= '0;
      hold     <= '0;
    end else begin
      rom_ce  <= fetch & de;
      pend_v  <= {pend_v[0], fetch};
      pend_de <= {pend_de[0], fetch & de};
      if (fetch) begin
        rom_a    <= {code_a, row};
        hold_de  <= de;
        hold_inv <= inv_in;
      end
      // Blanked cells capture zero so a later shift load never shows stale glyph data.
      if (pend_v[1]) hold <= pend_de[1] ? rom_q : '0;
    end
  end

  // Pixel side: loads the previous cell's byte on each ld, then shifts with zero fill.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift   <= '0;
      pixel   <= 1'b0;
      de_out  <= 1'b0;
      inv_out <= 1'b0;
    end else if (pe) begin
      if (ld) begin
        shift   <= hold;
        de_out  <= hold_de;
        inv_out <= hold_inv;
        pixel   <= hold[DW-1] ^ (hold_inv & hold_de);
      end else begin
        shift <= shift << 1;
        pixel <= shift[DW-2] ^ (inv_out & de_out);
      end
    end
  end

endmodule

// File: doc/char_pixel_shifter.md
Name: char_pixel_shifter

Overview:
- Video-path stage that sits directly upstream and downstream of the character-generator ROM.
- Takes a character code and scan-row from the CRTC/video-RAM side and issues a single-clock read strobe and address to the char ROM.
- The ROM returns its byte one clock later; this block captures the byte and serialises it MSB-first as one pixel per pixel-clock enable.
- Output is aligned one character period behind the code input, with display-enable delayed to match.

Parameters:
- DW, 8, pixels per character cell; also the ROM data width.
- CW, 8, character code width.
- RW, 3, scan-row address width (2^RW rows per glyph).
- AW = CW+RW, derived, ROM address width. Default 11, which is a 2 KB ROM.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- pe  in  1  pixel clock enable; all pixel/shift activity advances only when pe=1
- ld  in  1  character boundary strobe; qualified by pe
- code  in  CW  character code for the next cell
- row  in  RW  scan-row within the glyph
- de  in  1  display enable for the next cell
- rom_ce  out  1  ROM read strobe
- rom_a  out  AW  ROM address, {code,row}
- rom_q  in  DW  ROM data; valid on the clock after rom_ce
- pixel  out  1  serial pixel
- de_out  out  1  delayed display enable, aligned with pixel

Behaviour:
- One clock domain: clock. Reset is synchronous and active-high.
- Reset: rom_ce=0, rom_a=0, pixel=0, de_out=0; hold, hold_de, shift, fetch-pending flag and inverse bits all cleared.
- Fetch (clock with pe&ld):
  - rom_a <= {code,row}, registered.
  - rom_ce <= de; it is high for exactly one clock, and 0 on every other clock.
  - hold_de <= de.
  - If de=0, no ROM read is issued and hold is forced to 0 on capture.
- Capture: on the second clock after the fetch edge (ROM q valid), hold <= rom_q if the fetch had de=1, else 0. Implemented as a 2-deep pending pipe.
- Shift:
  - On pe&ld: shift <= hold, de_out <= hold_de, pixel <= hold[DW-1], using pre-update values.
  - On pe without ld: shift <= shift<<1 with a zero fill, pixel <= shift[DW-2].
  - pe=0: all pixel-side state holds.
- Latency: pixel data for a code appears one full character period later, starting at the next pe&ld after its fetch.
- ld without pe is ignored.
- More than DW pe cycles without ld: pixel=0 (zero fill), de_out holds its last value.
- Minimum ld spacing is 3 clocks. If ld recurs before capture, the shift register loads the stale hold and the new fetch proceeds normally. There is no error flag.
- Fetch and capture on the same clock: capture writes hold; the shift load in that cycle sees the old hold.
- Reset mid-line: everything clears at once; the first pixel data follows two ld strobes after reset.

Optional Feature:
- Macro INVERSE_VIDEO_EN.
- Defined:
  - code[CW-1] is an inverse flag. rom_a code field = {1'b0, code[CW-2:0]}.
  - The flag is pipelined alongside hold_de.
  - When the flag is set and de is active, the pixel is the complement of the shift MSB. Zero-fill past DW then yields 1 while inverse is active.
- Undefined: full code goes to the ROM and there is no inversion. Port list is identical either way.

Test Plan:
- Reset: hold reset 3 clocks with pe=1 -> rom_ce=0, rom_a=0, pixel=0, de_out=0.
- Basic read: pe=1 every clock, ld every 8 clocks. code=8'h41, row=3, de=1 -> rom_ce high one clock with rom_a=11'h20B. Bench ROM returns 8'hA5. At the next ld, pixel sequence = 1,0,1,0,0,1,0,1 and de_out=1.
- Blanking: de=0 with code=8'hFF -> no rom_ce pulse; the next cell outputs 8 zeros with de_out=0.
- pe gating: pe every 2nd clock, byte 8'h81 -> each pixel lasts 2 clocks; 1 then six 0s then 1; ld with pe=0 produces no fetch.
- Overrun: ld gap of 10 pe after byte 8'hFF -> 8 ones then 2 zeros.
- INVERSE_VIDEO_EN: code=8'hC1, byte 8'h0F -> rom_a code field 8'h41; pixels 1,1,1,1,0,0,0,0.
